ps2_host_tx: RTL

Host-to-device PS/2 transmitter: the sending end of the keyboard link whose receive side already feeds `key_data`/`ready` to the CPU bus. It accepts a byte from the CPU I/O write path and serialises it to the keyboard using the PS/2 host request-to-send protocol, for commands such as 0xED (set LEDs) and 0xFF (reset). It drives the PS/2 clock and data lines through open-drain enables, reports the device ACK bit, and flags a timeout. `busy` lets the top level hold off the keyboard receiver while a frame is in flight.

---
 rtl/ps2_host_tx.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/ps2_host_tx.sv
// Purpose: PS/2 host-to-device transmitter (request-to-send, odd parity, LSB first, ACK check, timeout).
// Latency: clock inhibit starts on the edge a write is accepted; data bits follow device clock falls by 3 cycles.
// Backpressure: busy is high from accept to completion; writes seen while busy are dropped.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 750000
) (
    input  logic       clk,
    input  logic       clrn,
    input  logic       io_wrn,
    input  logic [7:0] din,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       busy,
    output logic       done,
    output logic       err
);

    localparam int CNT_MAX = (TIMEOUT_CYCLES > INHIBIT_CYCLES) ? TIMEOUT_CYCLES : INHIBIT_CYCLES;
    localparam int TW      = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_REQ,
        S_SEND,
        S_WAIT_IDLE
    } state_t;

    state_t          state_q, state_d;
    logic [TW-1:0]   tcnt_q, tcnt_d;
    logic [3:0]      bcnt_q, bcnt_d;
    logic [7:0]      data_q, data_d;
    logic            par_q, par_d;
    logic            clk_oe_q, clk_oe_d;
    logic            data_oe_q, data_oe_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            err_q, err_d;
    logic [2:0]      clk_sync_q;
    logic [1:0]      dat_sync_q;
    logic            fall;
    logic            timeout;

    // Synchronise the pad inputs; third clock flop gives the falling-edge strobe.
    // Reset to 1 (idle bus) so leaving reset never produces a false fall.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            clk_sync_q <= 3'b111;
            dat_sync_q <= 2'b11;
        end else begin
            clk_sync_q <= {clk_sync_q[1:0], ps2_clk_in};
            dat_sync_q <= {dat_sync_q[0], ps2_data_in};
        end
    end

    assign fall    = clk_sync_q[2] & ~clk_sync_q[1];
    assign timeout = (tcnt_q == TW'(TIMEOUT_CYCLES - 1));

    // State and registered outputs.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q   <= S_IDLE;
            tcnt_q    <= '0;
            bcnt_q    <= '0;
            data_q    <= '0;
            par_q     <= 1'b0;
            clk_oe_q  <= 1'b0;
            data_oe_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            tcnt_q    <= tcnt_d;
            bcnt_q    <= bcnt_d;
            data_q    <= data_d;
            par_q     <= par_d;
            clk_oe_q  <= clk_oe_d;
            data_oe_q <= data_oe_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    // Next-state and next-output logic; outputs are computed one cycle ahead so they leave registered.
    always_comb begin
        state_d   = state_q;
        bcnt_d    = bcnt_q;
        data_d    = data_q;
        par_d     = par_q;
        clk_oe_d  = clk_oe_q;
        data_oe_d = data_oe_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        err_d     = err_q;
        tcnt_d    = '0;

        case (state_q)
            S_IDLE: begin
                clk_oe_d  = 1'b0;
                data_oe_d = 1'b0;
                bcnt_d    = '0;
                if (!io_wrn) begin
                    data_d   = din;
                    par_d    = ~^din;
                    busy_d   = 1'b1;
                    err_d    = 1'b0;
                    clk_oe_d = 1'b1;
                    state_d  = S_INHIBIT;
                end
            end
            S_INHIBIT: begin
                clk_oe_d = 1'b1;
                if (tcnt_q == TW'(INHIBIT_CYCLES - 1)) begin
                    data_oe_d = 1'b1;  // start bit
                    state_d   = S_REQ;
                end
            end
            S_REQ: begin
                clk_oe_d  = 1'b0;
                data_oe_d = 1'b1;
                bcnt_d    = '0;
                state_d   = S_SEND;
            end
            S_SEND: begin
                clk_oe_d = 1'b0;
                if (timeout) begin
                    data_oe_d = 1'b0;
                    err_d     = 1'b1;
                    done_d    = 1'b1;
                    busy_d    = 1'b0;
                    state_d   = S_IDLE;
                end else if (fall) begin
                    bcnt_d = bcnt_q + 4'd1;
                    case (bcnt_d)
                        4'd1, 4'd2, 4'd3, 4'd4,
                        4'd5, 4'd6, 4'd7, 4'd8: data_oe_d = ~data_q[bcnt_q[2:0]];
                        4'd9:                   data_oe_d = ~par_q;
                        4'd10:                  data_oe_d = 1'b0;
                        default: begin
                            // Eleventh fall: device should be holding data low as ACK.
                            data_oe_d = 1'b0;
                            err_d     = dat_sync_q[1];
                            state_d   = S_WAIT_IDLE;
                        end
                    endcase
                end
            end
            S_WAIT_IDLE: begin
                clk_oe_d  = 1'b0;
                data_oe_d = 1'b0;
                if (timeout) begin
                    err_d   = 1'b1;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end else if (clk_sync_q[1] && dat_sync_q[1]) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                clk_oe_d  = 1'b0;
                data_oe_d = 1'b0;
                busy_d    = 1'b0;
                state_d   = S_IDLE;
            end
        endcase

        // Shared counter: restarts on every state change, and on device clock falls while the device is clocking.
        if (state_d != state_q) begin
            tcnt_d = '0;
        end else if (fall && (state_q == S_SEND || state_q == S_WAIT_IDLE)) begin
            tcnt_d = '0;
        end else if (state_q == S_IDLE) begin
            tcnt_d = '0;
        end else begin
            tcnt_d = tcnt_q + TW'(1);
        end
    end

    assign ps2_clk_oe  = clk_oe_q;
    assign ps2_data_oe = data_oe_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign err         = err_q;

endmodule
